// File: rtl/jtsdram_pkg.sv
// Shared types and helpers for the SDRAM bank read checker.
// The pattern function is also used by the bank programmer, so the
// write and read sides of the harness always agree on the data.
package jtsdram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        CHK,
        DONE
    } state_e;

    localparam int ERR_W = 8;

    // Test word for one address: the key is replicated to 16 bits, mixed
    // with the reference word, then offset by the low address bits.
    function automatic logic [15:0] jtsdram_pattern(
        input logic [4:0]  key,
        input logic [15:0] data_ref,
        input logic [15:0] addr16
    );
        return ({key, key, key, key[4]} ^ data_ref) + addr16;
    endfunction

endpackage

// File: rtl/jtsdram_bank_rd_if.sv
// Read port between a bank checker (master) and its SDRAM controller port
// (slave): request/acknowledge for the address, strobe for the data.
interface jtsdram_bank_rd_if #(
    parameter int AW = 22
);
    logic [AW-1:0] ba_addr;
    logic          ba_rd;
    logic          ba_ack;
    logic          ba_rdy;
    logic [15:0]   din;

    modport master (
        output ba_addr,
        output ba_rd,
        input  ba_ack,
        input  ba_rdy,
        input  din
    );

    modport slave (
        input  ba_addr,
        input  ba_rd,
        output ba_ack,
        output ba_rdy,
        output din
    );
endinterface

// File: rtl/jtsdram_bank_cmp.sv
// Data capture and compare stage of the bank checker. Holds the word read
// from SDRAM, compares it against the expected pattern when told to, and
// keeps the sticky bad flag, a saturating error count and the address of
// the first mismatch in the current window.
module jtsdram_bank_cmp
    import jtsdram_pkg::*;
#(
    parameter int AW = 22
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,        // new window: clear flag and count
    input  logic             cap_en,     // latch din this cycle
    input  logic [15:0]      din,
    input  logic             chk_en,     // compare the latched word
    input  logic [15:0]      exp_word,
    input  logic [AW-1:0]    addr,       // address of the word being checked
    input  logic             fault,      // external abort marks the window bad
    output logic             bad,
    output logic [ERR_W-1:0] err_cnt,
    output logic [AW-1:0]    err_addr
);

    logic [15:0]      data_q, data_d;
    logic             bad_q, bad_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [AW-1:0]    err_addr_q, err_addr_d;

    // Next-state for the captured word and the error bookkeeping.
    always_comb begin
        data_d     = data_q;
        bad_d      = bad_q;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        if (cap_en) begin
            data_d = din;
        end
        if (clr) begin
            bad_d     = 1'b0;
            err_cnt_d = '0;
        end else begin
            if (chk_en && (data_q != exp_word)) begin
                bad_d = 1'b1;
                if (err_cnt_q != '1) begin
                    err_cnt_d = err_cnt_q + 1'b1;
                end
                // Only the first failing address of a window is kept.
                if (err_cnt_q == '0) begin
                    err_addr_d = addr;
                end
            end
            if (fault) begin
                bad_d = 1'b1;
            end
        end
    end

    // Register stage, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q     <= '0;
            bad_q      <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else begin
            data_q     <= data_d;
            bad_q      <= bad_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign bad      = bad_q;
    assign err_cnt  = err_cnt_q;
    assign err_addr = err_addr_q;

endmodule

// File: rtl/jtsdram_bank_rd.sv
// Per-bank read checker. A start pulse walks a 2**CW word window of one
// bank, reading each word through the controller port and checking it
// against jtsdram_pattern(). done stays high from the end of a window until
// the next start.
// Optional feature macro: JTSDRAM_TIMEOUT_EN -- aborts a window when the
// controller does not answer within TOUT cycles and raises tout.
module jtsdram_bank_rd
    import jtsdram_pkg::*;
#(
    parameter int AW   = 22,
    parameter int CW   = 10,
    parameter int TOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       key,
    input  logic [15:0]      data_ref,
    input  logic             start,
    output logic             done,
    jtsdram_bank_rd_if.master ba,
    output logic             bad,
    output logic [ERR_W-1:0] err_cnt,
    output logic [AW-1:0]    err_addr,
    output logic             tout
);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          rd_q, rd_d;
    logic          done_q, done_d;

    logic          clr, cap_en, chk_en, to_evt, tmr_hit;
    logic [AW-1:0] base;
    logic [15:0]   exp_word;

    // The key selects the top of the bank; the window starts there.
    assign base     = {key, {(AW-5){1'b0}}};
    // addr_q still holds the word under check while in CHK.
    assign exp_word = jtsdram_pattern(key, data_ref, addr_q[15:0]);

    // FSM next state, request/address generation and done flag.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rd_d    = rd_q;
        done_d  = done_q;
        clr     = 1'b0;
        cap_en  = 1'b0;
        chk_en  = 1'b0;
        to_evt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    clr     = 1'b1;
                    cnt_d   = '0;
                    addr_d  = base;
                    rd_d    = 1'b1;
                    done_d  = 1'b0;
                end
            end
            REQ: begin
                if (ba.ba_ack) begin
                    rd_d = 1'b0;
                    // Data arriving with the acknowledge is taken directly.
                    if (ba.ba_rdy) begin
                        cap_en  = 1'b1;
                        state_d = CHK;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (tmr_hit) begin
                    rd_d    = 1'b0;
                    to_evt  = 1'b1;
                    state_d = DONE;
                end
            end
            WAIT: begin
                if (ba.ba_rdy) begin
                    cap_en  = 1'b1;
                    state_d = CHK;
                end else if (tmr_hit) begin
                    to_evt  = 1'b1;
                    state_d = DONE;
                end
            end
            CHK: begin
                chk_en = 1'b1;
                if (cnt_q == '1) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    addr_d  = base + {{(AW-CW){1'b0}}, cnt_q + 1'b1};
                    rd_d    = 1'b1;
                    state_d = REQ;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM and bus registers; reset drops any pending request at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
        end
    end

`ifdef JTSDRAM_TIMEOUT_EN
    logic [7:0] tmr_q, tmr_d;
    logic       tout_q, tout_d;

    assign tmr_hit = (tmr_q == 8'(TOUT));

    // Watchdog restarts on every state change and only runs while the
    // controller owes us an acknowledge or data.
    always_comb begin
        tmr_d  = tmr_q;
        tout_d = tout_q;
        if (state_d != state_q) begin
            tmr_d = '0;
        end else if ((state_q == REQ) || (state_q == WAIT)) begin
            tmr_d = tmr_q + 8'd1;
        end
        if (clr) begin
            tout_d = 1'b0;
        end else if (to_evt) begin
            tout_d = 1'b1;
        end
    end

    // Watchdog registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_q  <= '0;
            tout_q <= 1'b0;
        end else begin
            tmr_q  <= tmr_d;
            tout_q <= tout_d;
        end
    end

    assign tout = tout_q;
`else
    // Without the watchdog the checker waits for the controller forever.
    assign tmr_hit = 1'b0;
    assign tout    = 1'b0;
`endif

    jtsdram_bank_cmp #(
        .AW(AW)
    ) u_cmp (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .cap_en   (cap_en),
        .din      (ba.din),
        .chk_en   (chk_en),
        .exp_word (exp_word),
        .addr     (addr_q),
        .fault    (to_evt),
        .bad      (bad),
        .err_cnt  (err_cnt),
        .err_addr (err_addr)
    );

    assign ba.ba_addr = addr_q;
    assign ba.ba_rd   = rd_q;
    assign done       = done_q;

endmodule

// File: tb/tb_jtsdram_bank_rd.sv
// Bench for jtsdram_bank_rd: a small-window instance (CW=2) with a
// configurable controller model, and a CW=9 instance fed wrong data on
// every word. Expected requests and window results go into queues when a
// window is started; monitors pop and compare as the DUT produces them.
module tb_jtsdram_bank_rd;
    localparam int AW     = 22;
    localparam int CW_A   = 2;
    localparam int CW_B   = 9;
    localparam int TOUT_A = 20;

    typedef struct {
        logic          bad;
        logic [7:0]    ec;
        logic [AW-1:0] ea;
        bit            chk_ea;
        logic          tout;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]    key_a, key_b;
    logic [15:0]   ref_a, ref_b;
    logic          start_a, start_b;
    logic          done_a, bad_a, tout_a, done_b, bad_b, tout_b;
    logic [7:0]    ec_a, ec_b;
    logic [AW-1:0] ea_a, ea_b;

    jtsdram_bank_rd_if #(.AW(AW)) ifa ();
    jtsdram_bank_rd_if #(.AW(AW)) ifb ();

    jtsdram_bank_rd #(.AW(AW), .CW(CW_A), .TOUT(TOUT_A)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .key(key_a), .data_ref(ref_a), .start(start_a),
        .done(done_a), .ba(ifa), .bad(bad_a), .err_cnt(ec_a), .err_addr(ea_a), .tout(tout_a)
    );

    jtsdram_bank_rd #(.AW(AW), .CW(CW_B), .TOUT(255)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .key(key_b), .data_ref(ref_b), .start(start_b),
        .done(done_b), .ba(ifb), .bad(bad_b), .err_cnt(ec_b), .err_addr(ea_b), .tout(tout_b)
    );

    int n_total = 0;
    int n_bad   = 0;

    logic [AW-1:0] addr_qa[$];
    res_t          res_qa[$];
    res_t          res_qb[$];

    // controller model controls for instance A
    int ack_dly = 1;
    int rdy_dly = 1;
    bit no_rdy = 1'b0;
    int corrupt_idx = -1;
    int stray_req = 0;
    int stray_done = 0;
    bit hold_chk = 1'b0;
    int hold_exp = 0;

    logic [AW-1:0] base_a, base_b;
    assign base_a = 22'h140000;   // key 0x0A in bits 21:17
    assign base_b = 22'h260000;   // key 0x13 in bits 21:17

    function automatic logic [15:0] pat(input logic [4:0] k, input logic [15:0] r,
                                        input logic [15:0] a);
        logic [15:0] rep;
        rep = {k, k, k, k[4]};
        return (rep ^ r) + a;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input string what);
        n_total++;
        n_bad++;
        $display("FAIL %s: %s", name, what);
    endtask

    // Controller model for A: ack after ack_dly cycles of ba_rd, data
    // rdy_dly cycles after ack; can corrupt one word or inject a stray rdy.
    initial begin : ctrl_a
        logic [AW-1:0] a;
        logic [15:0]   w;
        ifa.ba_ack = 1'b0;
        ifa.ba_rdy = 1'b0;
        ifa.din    = '0;
        forever begin
            @(posedge clk); #1;
            ifa.ba_ack = 1'b0;
            ifa.ba_rdy = 1'b0;
            if (stray_req != stray_done) begin
                ifa.ba_rdy = 1'b1;
                ifa.din    = 16'hDEAD;
                stray_done++;
            end else if (ifa.ba_rd) begin
                for (int i = 1; i < ack_dly; i++) begin @(posedge clk); #1; end
                a = ifa.ba_addr;
                ifa.ba_ack = 1'b1;
                @(posedge clk); #1;
                ifa.ba_ack = 1'b0;
                if (!no_rdy) begin
                    for (int i = 1; i < rdy_dly; i++) begin @(posedge clk); #1; end
                    w = pat(key_a, ref_a, a[15:0]);
                    if (corrupt_idx >= 0 && int'(a[CW_A-1:0]) == corrupt_idx) w = w ^ 16'h0001;
                    ifa.ba_rdy = 1'b1;
                    ifa.din    = w;
                end
            end
        end
    end

    // Controller model for B: zero wait, ack and data together, always wrong.
    initial begin : ctrl_b
        ifb.ba_ack = 1'b0;
        ifb.ba_rdy = 1'b0;
        ifb.din    = '0;
        forever begin
            @(posedge clk); #1;
            ifb.ba_ack = ifb.ba_rd;
            ifb.ba_rdy = ifb.ba_rd;
            ifb.din    = pat(key_b, ref_b, ifb.ba_addr[15:0]) ^ 16'h8000;
        end
    end

    // Monitor A: accepted requests against the address queue, window
    // results against the result queue when done rises.
    initial begin : mon_a
        logic dp;
        res_t r;
        logic [AW-1:0] ea;
        dp = 1'b0;
        forever begin
            @(negedge clk);
            if (ifa.ba_rd && ifa.ba_ack) begin
                if (addr_qa.size() == 0) begin
                    fail("req_addr", $sformatf("got request at %0h, required none", ifa.ba_addr));
                end else begin
                    ea = addr_qa.pop_front();
                    check("req_addr", ifa.ba_addr, ea);
                end
            end
            if (done_a && !dp) begin
                if (res_qa.size() == 0) begin
                    fail("done_a", "got done rise, required none");
                end else begin
                    r = res_qa.pop_front();
                    check("bad_a", bad_a, r.bad);
                    check("err_cnt_a", ec_a, r.ec);
                    if (r.chk_ea) check("err_addr_a", ea_a, r.ea);
                    check("tout_a", tout_a, r.tout);
                end
            end
            dp = done_a;
        end
    end

    // Monitor B: window result when done rises.
    initial begin : mon_b
        logic dp;
        res_t r;
        dp = 1'b0;
        forever begin
            @(negedge clk);
            if (done_b && !dp) begin
                if (res_qb.size() == 0) begin
                    fail("done_b", "got done rise, required none");
                end else begin
                    r = res_qb.pop_front();
                    check("bad_b", bad_b, r.bad);
                    check("err_cnt_b", ec_b, r.ec);
                    check("err_addr_b", ea_b, r.ea);
                end
            end
            dp = done_b;
        end
    end

    // Length of each ba_rd high phase on A.
    initial begin : mon_hold
        int run;
        run = 0;
        forever begin
            @(negedge clk);
            if (ifa.ba_rd) begin
                run++;
            end else begin
                if (run > 0 && hold_chk) check("rd_hold", run, hold_exp);
                run = 0;
            end
        end
    end

    task automatic start_run_a(input int nwords, input res_t r);
        for (int i = 0; i < nwords; i++) addr_qa.push_back(base_a + AW'(i));
        res_qa.push_back(r);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        check("done_fall", done_a, 1'b0);
        check("rd_rise", ifa.ba_rd, 1'b1);
        check("addr_first", ifa.ba_addr, base_a);
    endtask

    task automatic wait_done_a(input int budget);
        int n;
        n = 0;
        while (!done_a && n < budget) begin @(posedge clk); #1; n++; end
        if (!done_a) fail("done_a_wait", $sformatf("got no done, required within %0d cycles", budget));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_acks_a(input int nacks);
        int n, seen;
        n = 0;
        seen = 0;
        while (seen < nacks && n < 200) begin
            @(posedge clk); #2;
            if (ifa.ba_ack) seen++;
            n++;
        end
        if (seen < nacks) fail("ack_wait", $sformatf("got %0d acks, required %0d", seen, nacks));
    endtask

    initial begin : stim
        int n;
        key_a = 5'h0A; ref_a = 16'hAAAA; start_a = 1'b0;
        key_b = 5'h13; ref_b = 16'h1234; start_b = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", done_a, 1'b0);
        check("rst_rd", ifa.ba_rd, 1'b0);
        check("rst_addr", ifa.ba_addr, 0);
        check("rst_bad", bad_a, 1'b0);
        check("rst_err_cnt", ec_a, 0);
        check("rst_err_addr", ea_a, 0);
        check("rst_tout", tout_a, 1'b0);
        check("rst_done_b", done_b, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // clean window
        start_run_a(4, '{bad: 1'b0, ec: 8'd0, ea: '0, chk_ea: 1'b1, tout: 1'b0});
        wait_done_a(200);

        // word 2 corrupted
        corrupt_idx = 2;
        start_run_a(4, '{bad: 1'b1, ec: 8'd1, ea: 22'h140002, chk_ea: 1'b1, tout: 1'b0});
        wait_done_a(200);
        corrupt_idx = -1;

        // stray rdy in IDLE must not disturb anything
        stray_req++;
        repeat (3) @(posedge clk);
        #1;
        check("stray_done", done_a, 1'b1);
        check("stray_rd", ifa.ba_rd, 1'b0);
        check("stray_bad", bad_a, 1'b1);

        // slow handshake, second start during WAIT
        ack_dly = 5; rdy_dly = 3; hold_exp = 5; hold_chk = 1'b1;
        start_run_a(4, '{bad: 1'b0, ec: 8'd0, ea: '0, chk_ea: 1'b0, tout: 1'b0});
        wait_acks_a(1);
        @(posedge clk); #2;
        start_a = 1'b1;
        @(posedge clk); #2;
        start_a = 1'b0;
        wait_done_a(400);
        hold_chk = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("no_extra_rd", ifa.ba_rd, 1'b0);
        check("addr_q_left", addr_qa.size(), 0);

        // reset during WAIT of word 1, after word 0 has already failed
        ack_dly = 1; rdy_dly = 3; corrupt_idx = 0;
        start_run_a(4, '{bad: 1'b1, ec: 8'd1, ea: '0, chk_ea: 1'b0, tout: 1'b0});
        wait_acks_a(2);
        @(posedge clk); #3;
        check("pre_rst_bad", bad_a, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd", ifa.ba_rd, 1'b0);
        check("mid_rst_done", done_a, 1'b0);
        check("mid_rst_bad", bad_a, 1'b0);
        check("mid_rst_err_cnt", ec_a, 0);
        check("mid_rst_err_addr", ea_a, 0);
        addr_qa.delete();
        res_qa.delete();
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b1;
        corrupt_idx = -1;
        repeat (8) @(posedge clk);
        #1;
        start_run_a(4, '{bad: 1'b0, ec: 8'd0, ea: '0, chk_ea: 1'b1, tout: 1'b0});
        wait_done_a(200);

`ifdef JTSDRAM_TIMEOUT_EN
        // controller acknowledges but never returns data
        no_rdy = 1'b1;
        start_run_a(1, '{bad: 1'b1, ec: 8'd0, ea: '0, chk_ea: 1'b0, tout: 1'b1});
        wait_acks_a(1);
        @(posedge clk);
        n = 0;
        while (!tout_a && n < 60) begin @(posedge clk); #1; n++; end
        check("tout_cycles", n, 21);
        wait_done_a(10);
        no_rdy = 1'b0;
        repeat (10) @(posedge clk);
        #1;
`endif

        // every word wrong on a 512-word window
        res_qb.push_back('{bad: 1'b1, ec: 8'd255, ea: 22'h260000, chk_ea: 1'b1, tout: 1'b0});
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        check("b_rd_rise", ifb.ba_rd, 1'b1);
        check("b_addr_first", ifb.ba_addr, base_b);
        n = 0;
        while (!done_b && n < 4000) begin @(posedge clk); #1; n++; end
        if (!done_b) fail("done_b_wait", "got no done, required within 4000 cycles");
        repeat (3) @(posedge clk);
        #1;
        check("res_qa_left", res_qa.size(), 0);
        check("res_qb_left", res_qb.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
